tl45_fetch: RTL and testbench

//   Instruction fetch stage; writer side of the fetch->decode buffer (o_buf_pc/o_buf_inst).

---
 rtl/tl45_fetch_if.sv | 33 +++
 rtl/tl45_fetch.sv | 175 +++++++++++++++++
 tb/tb_tl45_fetch.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl45_fetch_if.sv
// Pipelined-Wishbone read port used by the tl45 fetch stage.
//
// Signals (seen from the master side):
//   cyc   out  1   bus cycle active
//   stb   out  1   request strobe
//   we    out  1   write enable (fetch only reads)
//   sel   out  4   byte lane select
//   addr  out  30  word address
//   ack   in   1   read data valid
//   stall in   1   slave not accepting the strobe
//   err   in   1   bus error, replaces ack
//   data  in   32  read data
interface tl45_fetch_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [29:0] addr;
    logic        ack;
    logic        stall;
    logic        err;
    logic [31:0] data;

    modport master (
        output cyc, stb, we, sel, addr,
        input  ack, stall, err, data
    );

    modport slave (
        input  cyc, stb, we, sel, addr,
        output ack, stall, err, data
    );
endinterface

// File: rtl/tl45_fetch.sv
// tl45 instruction fetch stage: writer side of the fetch->decode buffer.
// Issues one outstanding Wishbone word read at a time at the current PC and
// presents each returned word to decode, emitting bubbles (pc=0, inst=0) when
// nothing is ready. Honours decode stall (outputs hold) and flush (restart at
// a new PC). A bus error presents a faulting slot and halts fetch until flush.
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_pipe_stall        decode cannot accept; o_buf_* hold
//   i_pipe_flush        discard in-flight work, restart at i_new_pc
//   i_new_pc            redirect target (low two bits ignored)
//   wb                  Wishbone master port (tl45_fetch_if.master)
//   o_buf_pc/inst/err   presented slot: PC, instruction (0 = bubble), fault flag
module tl45_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_pipe_stall,
    input  logic         i_pipe_flush,
    input  logic [31:0]  i_new_pc,
    tl45_fetch_if.master wb,
    output logic [31:0]  o_buf_pc,
    output logic [31:0]  o_buf_inst,
    output logic         o_buf_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        cyc_reg;
    logic        stb_reg;
    logic [29:0] addr_reg;
    logic [31:0] buf_pc_reg;
    logic [31:0] buf_inst_reg;
    logic        buf_err_reg;
    logic [31:0] skid_pc_reg;
    logic [31:0] skid_inst_reg;
    logic        skid_err_reg;

    logic        resp;
    logic [31:0] resp_inst;

    // Redirect targets are word aligned; the two low bits carry no meaning.
    wire unused_new_pc_lsbs = &{1'b0, i_new_pc[1:0]};

    assign resp      = wb.ack | wb.err;
    assign resp_inst = wb.err ? 32'h0 : wb.data;

    assign wb.cyc  = cyc_reg;
    assign wb.stb  = stb_reg;
    assign wb.we   = 1'b0;
    assign wb.sel  = 4'hF;
    assign wb.addr = addr_reg;

    assign o_buf_pc   = buf_pc_reg;
    assign o_buf_inst = buf_inst_reg;
    assign o_buf_err  = buf_err_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= S_IDLE;
            pc_reg        <= RESET_PC;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            addr_reg      <= 30'h0;
            buf_pc_reg    <= 32'h0;
            buf_inst_reg  <= 32'h0;
            buf_err_reg   <= 1'b0;
            skid_pc_reg   <= 32'h0;
            skid_inst_reg <= 32'h0;
            skid_err_reg  <= 1'b0;
        end else if (i_pipe_flush) begin
            // Dropping cyc aborts any open cycle; a response arriving in this
            // same cycle belongs to the discarded path and is ignored.
            state_reg     <= S_IDLE;
            pc_reg        <= {i_new_pc[31:2], 2'b00};
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            buf_pc_reg    <= 32'h0;
            buf_inst_reg  <= 32'h0;
            buf_err_reg   <= 1'b0;
            skid_pc_reg   <= 32'h0;
            skid_inst_reg <= 32'h0;
            skid_err_reg  <= 1'b0;
        end else begin
            // Unstalled decode sees a bubble unless a word lands below.
            if (!i_pipe_stall) begin
                buf_pc_reg   <= 32'h0;
                buf_inst_reg <= 32'h0;
                buf_err_reg  <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    state_reg <= S_REQ;
                    cyc_reg   <= 1'b1;
                    stb_reg   <= 1'b1;
                    addr_reg  <= pc_reg[31:2];
                end

                S_REQ: begin
                    if (!wb.stall) begin
                        state_reg <= S_WAIT;
                        stb_reg   <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (resp) begin
                        cyc_reg <= 1'b0;
                        if (!i_pipe_stall) begin
                            buf_pc_reg   <= pc_reg;
                            buf_inst_reg <= resp_inst;
                            buf_err_reg  <= wb.err;
                        end else begin
                            skid_pc_reg   <= pc_reg;
                            skid_inst_reg <= resp_inst;
                            skid_err_reg  <= wb.err;
                        end
                        if (wb.err) begin
                            state_reg <= i_pipe_stall ? S_HOLD : S_ERR;
                        end else begin
                            // pc moves on now; the skid keeps the old pc
                            // for the word it holds.
                            pc_reg    <= pc_reg + 32'd4;
                            // Via IDLE so cyc is low for one cycle between
                            // back-to-back fetches.
                            state_reg <= i_pipe_stall ? S_HOLD : S_IDLE;
                        end
                    end
                end

                S_HOLD: begin
                    if (!i_pipe_stall) begin
                        buf_pc_reg    <= skid_pc_reg;
                        buf_inst_reg  <= skid_inst_reg;
                        buf_err_reg   <= skid_err_reg;
                        skid_pc_reg   <= 32'h0;
                        skid_inst_reg <= 32'h0;
                        skid_err_reg  <= 1'b0;
                        if (skid_err_reg) begin
                            state_reg <= S_ERR;
                        end else begin
                            // cyc has already been low while holding.
                            state_reg <= S_REQ;
                            cyc_reg   <= 1'b1;
                            stb_reg   <= 1'b1;
                            addr_reg  <= pc_reg[31:2];
                        end
                    end
                end

                S_ERR: begin
                    cyc_reg <= 1'b0;
                    stb_reg <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                    cyc_reg   <= 1'b0;
                    stb_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl45_fetch.sv
// Bench for tl45_fetch: a bus-level reference model (expected PC, outstanding
// request, skid slot, halt flag) predicts the presented slot and the legal bus
// activity every cycle; directed scenarios pin the model with literal values,
// then a long randomized run exercises stalls, flushes, errors and latency.
module tb_tl45_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_stall;
    logic        pipe_flush;
    logic [31:0] new_pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;
    logic        buf_err;

    always #5 clk = ~clk;

    tl45_fetch_if bus ();

    tl45_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_pipe_stall (pipe_stall),
        .i_pipe_flush (pipe_flush),
        .i_new_pc     (new_pc),
        .wb           (bus),
        .o_buf_pc     (buf_pc),
        .o_buf_inst   (buf_inst),
        .o_buf_err    (buf_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [64:0] m_exp;        // {pc, inst, err} decode must see
    logic [64:0] m_pend;
    logic        m_pend_valid; // word returned while decode stalled
    logic        m_halt;       // error seen, no fetch until flush
    logic        m_out;        // request accepted, response not yet seen
    logic        m_flushed;    // previous edge was a flush or reset
    int          m_lat;
    int          m_gap;
    int          m_words;

    // Slave behaviour controls
    logic [29:0] acc_addr;
    logic        err_en;
    logic [29:0] err_word;
    logic        rand_err;
    int          max_lat;
    logic        use_ovr;
    logic [29:0] ovr_word;
    logic [31:0] ovr_data;

    logic        s_stb;
    logic        s_cyc;
    logic [29:0] s_addr;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc         = 32'h0;
        m_exp        = '0;
        m_pend       = '0;
        m_pend_valid = 1'b0;
        m_halt       = 1'b0;
        m_out        = 1'b0;
        m_flushed    = 1'b1;
        m_lat        = 0;
        m_gap        = 0;
    endtask

    // Called at a negedge: outputs are settled and far from the active edge.
    task automatic check_outputs();
        s_stb  = bus.stb;
        s_cyc  = bus.cyc;
        s_addr = bus.addr;
        check("buf", {buf_pc, buf_inst, buf_err}, m_exp);
        check("we_sel", {bus.we, bus.sel}, 5'h0F);
        if (s_stb) begin
            check("stb_addr", s_addr, m_pc[31:2]);
            check("stb_while_busy", {m_out, m_pend_valid, m_halt}, 3'b000);
            check("stb_without_cyc", s_cyc, 1'b1);
        end
        if (m_out)
            check("wait_bus", {s_cyc, s_stb}, 2'b10);
        if (m_pend_valid || m_halt || m_flushed)
            check("cyc_low", s_cyc, 1'b0);
        if (!s_stb && !m_out && !m_pend_valid && !m_halt)
            m_gap++;
        else
            m_gap = 0;
        check("fetch_gap", m_gap > 1, 1'b0);
    endtask

    task automatic model_step(input logic ps, input logic fl, input logic [31:0] npc, input logic ws);
        logic [64:0] t;
        if (fl) begin
            m_exp        = '0;
            m_pend_valid = 1'b0;
            m_halt       = 1'b0;
            m_out        = 1'b0;
            m_pc         = {npc[31:2], 2'b00};
            m_flushed    = 1'b1;
            m_gap        = 0;
        end else begin
            m_flushed = 1'b0;
            if (m_out && (bus.ack || bus.err)) begin
                t = {m_pc, (bus.err ? 32'h0 : bus.data), bus.err};
                m_out = 1'b0;
                m_words++;
                if (bus.err) m_halt = 1'b1;
                else         m_pc = m_pc + 32'd4;
                if (ps) begin
                    m_pend_valid = 1'b1;
                    m_pend       = t;
                end else begin
                    m_exp = t;
                end
            end else if (m_pend_valid && !ps) begin
                m_exp        = m_pend;
                m_pend_valid = 1'b0;
            end else if (!ps) begin
                m_exp = '0;
            end
            if (s_stb && !ws) begin
                m_out    = 1'b1;
                acc_addr = s_addr;
                m_lat    = int'($urandom_range(0, max_lat));
            end
        end
    endtask

    // One clock: compare, drive inputs and the slave response, advance model.
    task automatic cycle(input logic ps, input logic fl, input logic [31:0] npc, input logic ws);
        check_outputs();
        pipe_stall = ps;
        pipe_flush = fl;
        new_pc     = npc;
        bus.stall  = ws;
        bus.ack    = 1'b0;
        bus.err    = 1'b0;
        bus.data   = $urandom;
        if (m_out) begin
            if (m_lat == 0) begin
                if ((err_en && acc_addr == err_word) || (rand_err && $urandom_range(0, 19) == 0)) begin
                    bus.err = 1'b1;
                end else begin
                    bus.ack  = 1'b1;
                    bus.data = (use_ovr && acc_addr == ovr_word) ? ovr_data
                                                                 : 32'h0800_0001 + {2'b00, acc_addr};
                end
            end else begin
                m_lat--;
            end
        end
        @(posedge clk);
        model_step(ps, fl, npc, ws);
        @(negedge clk);
    endtask

    task automatic run_until_word(input string name, output int n);
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end while (buf_inst == 32'h0 && buf_err == 1'b0 && n < 12);
        check({name, "_arrive"}, (buf_inst != 32'h0) || buf_err, 1'b1);
    endtask

    task automatic wait_stb(input string name);
        int n;
        n = 0;
        while (!bus.stb && n < 12) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        check({name, "_stb_seen"}, bus.stb, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        ps_r, fl_r, ws_r;
        logic [31:0] npc_r;

        rst        = 1'b1;
        pipe_stall = 1'b0;
        pipe_flush = 1'b0;
        new_pc     = 32'h0;
        bus.ack    = 1'b0;
        bus.err    = 1'b0;
        bus.stall  = 1'b0;
        bus.data   = 32'h0;
        err_en     = 1'b0;
        err_word   = 30'h0;
        rand_err   = 1'b0;
        max_lat    = 0;
        use_ovr    = 1'b0;
        ovr_word   = 30'h0;
        ovr_data   = 32'h0;
        acc_addr   = 30'h0;
        m_words    = 0;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_bus", {bus.cyc, bus.stb, bus.addr}, 32'h0);
        check("rst_buf", {buf_pc, buf_inst, buf_err}, 65'h0);
        rst = 1'b0;
        model_reset();

        // 1. Zero-wait fetch of pc 0x0 and 0x4, three cycles apart
        run_until_word("t1_w0", n);
        check("t1_w0_cycles", n, 3);
        check("t1_w0", {buf_pc, buf_inst, buf_err}, {32'h0, 32'h0800_0001, 1'b0});
        run_until_word("t1_w1", n);
        check("t1_w1_cycles", n, 3);
        check("t1_w1", {buf_pc, buf_inst, buf_err}, {32'h4, 32'h0800_0002, 1'b0});

        // 2. Decode stall spanning the ack of pc 0x8
        use_ovr  = 1'b1;
        ovr_word = 30'h2;
        ovr_data = 32'h0A12_3456;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            check("t2_frozen", {buf_pc, buf_inst}, {32'h4, 32'h0800_0002});
        end
        check("t2_cyc_low", bus.cyc, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("t2_release", {buf_pc, buf_inst, buf_err}, {32'h8, 32'h0A12_3456, 1'b0});
        use_ovr = 1'b0;

        // 3. Flush to 0x103 while waiting; the ack in the flush cycle is dropped
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_wait", {bus.cyc, bus.stb}, 2'b10);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        check("t3_abort", {bus.cyc, buf_pc, buf_inst, buf_err}, 66'h0);
        wait_stb("t3");
        check("t3_addr", bus.addr, 30'h40);

        // 4. Bus error at pc 0x20 halts fetch until a flush
        err_en   = 1'b1;
        err_word = 30'h8;
        cycle(1'b0, 1'b1, 32'h0000_0020, 1'b0);
        run_until_word("t4_err", n);
        check("t4_err", {buf_pc, buf_inst, buf_err}, {32'h20, 32'h0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            check("t4_halted", {bus.cyc, buf_inst, buf_err}, 34'h0);
        end
        err_en = 1'b0;
        cycle(1'b0, 1'b1, 32'h0, 1'b0);

        // 5. Slave stall holds strobe and address
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t5_stb_held", {bus.stb, bus.addr}, {1'b1, 30'h0});
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check("t5_stb_still", {bus.stb, bus.addr}, {1'b1, 30'h0});
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("t5_wait", {bus.cyc, bus.stb}, 2'b10);
        run_until_word("t5_w", n);
        check("t5_w", {buf_pc, buf_inst, buf_err}, {32'h0, 32'h0800_0001, 1'b0});

        // 6. PC wrap and asynchronous reset in WAIT
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_stb("t6_top");
        check("t6_top_addr", bus.addr, 30'h3FFF_FFFF);
        run_until_word("t6_top", n);
        check("t6_top_pc", buf_pc, 32'hFFFF_FFFC);
        wait_stb("t6_wrap");
        check("t6_wrap_addr", bus.addr, 30'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_wait", {bus.cyc, bus.stb}, 2'b10);
        bus.ack = 1'b0;
        bus.err = 1'b0;
        #2 rst = 1'b1;
        #1 check("t6_async_rst", {bus.cyc, bus.stb, buf_inst}, 34'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized run
        rand_err = 1'b1;
        max_lat  = 3;
        m_words  = 0;
        for (int i = 0; i < 4000; i++) begin
            ps_r  = ($urandom_range(0, 3) == 0);
            fl_r  = ($urandom_range(0, 39) == 0);
            ws_r  = ($urandom_range(0, 2) == 0);
            npc_r = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle(ps_r, fl_r, npc_r, ws_r);
        end
        check("rand_progress", m_words > 200, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
